// File: rtl/counter_step_ctrl.sv
// counter_step_ctrl
//   Sequencing controller for the up/down counter datapath. Turns the
//   debounced button level and the slow tick into one-cycle step commands.
//   Manual mode gives one step per press. A long press enters auto-run, which
//   issues a step every AUTO_DIV ticks. The controller reverses the step
//   direction at the MAX_VAL/MIN_VAL limits, and each reversal consumes one
//   request.
//
//   Build option: define COUNTER_WRAP_EN to disable bounce. In that build dir
//   stays 0, every request steps, and the counter wraps modulo 2^WIDTH.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active low
//   tick        one-cycle slow-rate enable
//   btn_level   debounced button level (1 = pressed)
//   count_in    current counter value, fed back from the counter
//   step_en     one-cycle step command to the counter
//   dir         step direction (0 = up, 1 = down)
//   auto_active high while in AUTO
//   state       FSM state (IDLE=00, HOLD=01, AUTO=10, WAIT_REL=11)

module counter_step_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MAX_VAL    = 15,
    parameter int MIN_VAL    = 0,
    parameter int HOLD_TICKS = 8,
    parameter int AUTO_DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_level,
    input  logic [WIDTH-1:0] count_in,
    output logic             step_en,
    output logic             dir,
    output logic             auto_active,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HOLD     = 2'b01,
        AUTO     = 2'b10,
        WAIT_REL = 2'b11
    } state_t;

    localparam int HW = $clog2(HOLD_TICKS);
    localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [AW-1:0]    DIV_LAST  = AW'(AUTO_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_C     = WIDTH'(MIN_VAL);

    state_t          st;
    logic            btn_prev;
    logic [HW-1:0]   hold_cnt;
    logic [AW-1:0]   div_cnt;
    logic            press;
    logic            req;

    assign state = st;

`ifdef COUNTER_WRAP_EN
    // The limits and the fed-back count do not matter when the counter wraps.
    logic unused_wrap;
    assign unused_wrap = ^{count_in, MAX_C, MIN_C};
`endif

    // Request generation: combinational, resolved on the next edge
    always_comb begin
        press = btn_level & ~btn_prev;
        req   = 1'b0;
        case (st)
            IDLE:    req = press;
            // A press in AUTO exits the mode, so it suppresses the boundary tick.
            AUTO:    req = tick & ~press & (div_cnt == DIV_LAST);
            default: req = 1'b0;
        endcase
    end

    // Registered stage: request resolution and FSM
    always_ff @(posedge clk) begin
        // btn_prev keeps sampling while reset is asserted. A button held
        // through reset therefore gives no press until it is released and
        // pressed again.
        btn_prev <= btn_level;

        if (!rst) begin
            st          <= IDLE;
            step_en     <= 1'b0;
            dir         <= 1'b0;
            auto_active <= 1'b0;
            hold_cnt    <= '0;
            div_cnt     <= '0;
        end else begin
            step_en <= 1'b0;
            if (req) begin
`ifdef COUNTER_WRAP_EN
                step_en <= 1'b1;
`else
                // A request that arrives at a limit flips direction and issues no step.
                if (!dir && count_in == MAX_C)
                    dir <= 1'b1;
                else if (dir && count_in == MIN_C)
                    dir <= 1'b0;
                else
                    step_en <= 1'b1;
`endif
            end

            case (st)
                IDLE: begin
                    if (press) begin
                        st       <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (!btn_level) begin
                        st <= IDLE;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            st          <= AUTO;
                            auto_active <= 1'b1;
                            div_cnt     <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                AUTO: begin
                    if (press) begin
                        st          <= WAIT_REL;
                        auto_active <= 1'b0;
                    end else if (tick) begin
                        if (div_cnt == DIV_LAST)
                            div_cnt <= '0;
                        else
                            div_cnt <= div_cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!btn_level)
                        st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
